// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared widths and FSM state type for the ram64 burst front-end.
package ram_ctrl_pkg;
    localparam int ADDR_W_DEF = 6;
    localparam int DATA_W_DEF = 16;
    typedef enum logic [1:0] {IDLE, WRITE, READ} ctrl_state_t;
endpackage

// File: rtl/ram64.sv
// ram64: 2^ADDR_W x DATA_W word store, synchronous write, combinational read, no reset.
module ram64
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] in,
    input  logic              load,
    output logic [DATA_W-1:0] out
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk)
        if (load) mem[address] <= in;
    assign out = mem[address];
endmodule

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: read/write burst initiator for ram64 with valid/ready command and data streams.
module ram_burst_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    input  logic [DATA_W-1:0] ram_out
);
    ctrl_state_t       state;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] remaining;
    logic [ADDR_W-1:0] last_addr;
    logic              wr_hs;
    logic              cap;
    // state resets asynchronously, so ram_load falls with rst_n without extra gating
    always_comb begin
        wr_hs       = state == WRITE && wr_valid;
        cap         = state == READ && (!rd_valid || rd_ready);
        cmd_ready   = state == IDLE && !rd_valid;
        wr_ready    = state == WRITE;
        ram_load    = wr_hs;
        ram_in      = state == WRITE ? wr_data : '0;
        ram_address = state == IDLE ? last_addr : cur_addr;
        busy        = state != IDLE || rd_valid;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            last_addr <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
        end else begin
            if (state != IDLE) last_addr <= cur_addr;
            if (cap) begin
                rd_data  <= ram_out;
                rd_valid <= 1'b1;
            end else if (rd_ready) begin
                rd_valid <= 1'b0;
            end
            case (state)
                IDLE: if (cmd_valid && cmd_ready) begin
                    cur_addr  <= cmd_addr;
                    remaining <= cmd_len;
                    state     <= cmd_write ? WRITE : READ;
                end
                WRITE, READ: if (wr_hs || cap) begin
                    cur_addr  <= cur_addr + 1'b1;
                    remaining <= remaining - 1'b1;
                    if (remaining == '0) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb_ram_burst_ctrl: burst controller plus ram64, checked each cycle against a beat-level model.
module tb_ram_burst_ctrl;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        cmd_valid = 0, cmd_ready, cmd_write = 0;
    logic [5:0]  cmd_addr = 0, cmd_len = 0;
    logic [15:0] wr_data = 0;
    logic        wr_valid = 0, wr_ready;
    logic [15:0] rd_data;
    logic        rd_valid, rd_ready = 1;
    logic        busy;
    logic [5:0]  ram_address;
    logic [15:0] ram_in, ram_out;
    logic        ram_load;

    int checks = 0, failures = 0;
    logic [15:0] got[$];
    logic [5:0]  lda[$];
    int busy_cnt = 0;

    logic [15:0] m_mem [64];
    bit          m_known [64];
    int          m_wl = 0, m_rl = 0;
    logic [5:0]  m_wa = 0, m_ra = 0, m_last = 0;
    bit          m_rv = 0, m_rk = 1;
    logic [15:0] m_rd = 0;

    ram_burst_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .busy(busy),
        .ram_address(ram_address), .ram_in(ram_in), .ram_load(ram_load), .ram_out(ram_out)
    );
    ram64 ram (.clk(clk), .address(ram_address), .in(ram_in), .load(ram_load), .out(ram_out));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // beat-level model: a burst is a count of beats left plus a running address
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_wl = 0; m_rl = 0; m_rv = 0; m_rd = 0; m_rk = 1;
            m_wa = 0; m_ra = 0; m_last = 0;
        end else begin
            bit cr;
            cr = m_wl == 0 && m_rl == 0 && !m_rv;
            if (m_wl > 0) begin
                m_last = m_wa;
                if (wr_valid) begin
                    m_mem[m_wa] = wr_data; m_known[m_wa] = 1;
                    m_wa++; m_wl--;
                end
            end
            if (m_rl > 0) m_last = m_ra;
            if (m_rl > 0 && (!m_rv || rd_ready)) begin
                m_rd = m_mem[m_ra]; m_rk = m_known[m_ra]; m_rv = 1;
                m_ra++; m_rl--;
            end else if (rd_ready) m_rv = 0;
            if (cmd_valid && cr) begin
                if (cmd_write) begin m_wl = int'(cmd_len) + 1; m_wa = cmd_addr; end
                else begin m_rl = int'(cmd_len) + 1; m_ra = cmd_addr; end
            end
        end
    end

    always @(negedge clk) begin
        bit cr;
        cr = m_wl == 0 && m_rl == 0 && !m_rv;
        chk("cmd_ready", cmd_ready, cr);
        chk("busy", busy, !cr);
        chk("wr_ready", wr_ready, m_wl > 0);
        chk("ram_load", ram_load, m_wl > 0 && wr_valid);
        chk("ram_in", ram_in, m_wl > 0 ? wr_data : 16'h0);
        chk("ram_address", ram_address, m_wl > 0 ? m_wa : m_rl > 0 ? m_ra : m_last);
        chk("rd_valid", rd_valid, m_rv);
        if (m_rk) chk("rd_data", rd_data, m_rd);
    end

    always @(negedge clk) begin
        if (rd_valid && rd_ready) got.push_back(rd_data);
        if (ram_load) lda.push_back(ram_address);
        if (busy) busy_cnt++;
    end

    task automatic send_cmd(input bit w, input logic [5:0] a, input logic [5:0] l);
        bit ok = 0;
        cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_len = l;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk); ok = cmd_ready;
            @(posedge clk); #1;
        end
        cmd_valid = 0; cmd_write = 1'($urandom);
        busy_cnt = 0;
        if (!ok) chk("cmd_timeout", 0, 1);
    endtask

    task automatic do_write(input logic [5:0] a, input logic [5:0] l, input logic [15:0] base, input bit rnd);
        int n = int'(l) + 1, i = 0;
        bit hs;
        send_cmd(1, a, l);
        for (int t = 0; t < 2000 && i < n; t++) begin
            wr_valid = rnd ? ($urandom_range(3) != 0) : 1'b1;
            wr_data = base + 16'(i);
            @(negedge clk); hs = wr_valid && wr_ready;
            @(posedge clk); #1;
            if (hs) i++;
        end
        wr_valid = 0;
        if (i < n) chk("write_timeout", i, n);
    endtask

    task automatic do_read(input logic [5:0] a, input logic [5:0] l, input bit rnd);
        int n = int'(l) + 1;
        got.delete();
        send_cmd(0, a, l);
        for (int t = 0; t < 2000 && got.size() < n; t++) begin
            rd_ready = rnd ? ($urandom_range(2) != 0) : 1'b1;
            @(negedge clk);
            @(posedge clk); #1;
        end
        rd_ready = 1;
        if (got.size() < n) chk("read_timeout", got.size(), n);
    endtask

    initial begin
        int pat[5] = '{1, 0, 0, 1, 1};
        int k;
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_ram_address", ram_address, 0);
        chk("rst_rd_data", rd_data, 0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;

        // single write then read, with first-beat latency
        do_write(0, 0, 16'habcd, 0);
        got.delete();
        send_cmd(0, 0, 0);
        @(negedge clk); chk("rd_valid_edge1", rd_valid, 0);
        @(negedge clk); chk("rd_valid_edge2", rd_valid, 1);
        chk("single_rd_data", rd_data, 16'habcd);
        @(posedge clk); #1;

        // wrapping burst
        do_write(62, 3, 16'h1001, 0);
        do_read(62, 3, 0);
        chk("wrap_cnt", got.size(), 4);
        for (int i = 0; i < got.size(); i++) chk("wrap_beat", got[i], 16'h1001 + 16'(i));
        do_read(0, 1, 0);
        chk("wrap_w0", got[0], 16'h1003);
        chk("wrap_w1", got[1], 16'h1004);

        // read backpressure
        rd_ready = 0;
        got.delete();
        send_cmd(0, 62, 3);
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin @(negedge clk); seen = rd_valid; end
        chk("bp_first", seen, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_stable", rd_data, 16'h1001);
            chk("bp_cmd_ready", cmd_ready, 0);
        end
        @(posedge clk); #1 rd_ready = 1;
        for (int t = 0; t < 50 && got.size() < 4; t++) begin @(posedge clk); #1; end
        chk("bp_cnt", got.size(), 4);
        for (int i = 0; i < got.size(); i++) chk("bp_beat", got[i], 16'h1001 + 16'(i));

        // gapped write
        lda.delete();
        send_cmd(1, 10, 2);
        k = 0;
        for (int p = 0; p < 5; p++) begin
            wr_valid = pat[p][0]; wr_data = 16'h2000 + 16'(k);
            @(posedge clk); #1;
            if (pat[p] != 0) k++;
        end
        wr_valid = 0;
        chk("stall_loads", lda.size(), 3);
        for (int i = 0; i < lda.size(); i++) chk("stall_addr", lda[i], 10 + i);

        // full depth, identity data
        do_write(0, 63, 16'h0, 0);
        repeat (3) @(posedge clk);
        #1 chk("full_busy", busy_cnt, 64);
        do_read(0, 63, 0);
        chk("full_cnt", got.size(), 64);
        for (int i = 0; i < got.size(); i++) chk("full_beat", got[i], i);

        // reset after two of five beats
        send_cmd(1, 20, 4);
        wr_valid = 1; wr_data = 16'he000;
        @(posedge clk); #1 wr_data = 16'he001;
        @(posedge clk); #1 wr_data = 16'he002;
        #2 chk("pre_rst_load", ram_load, 1);
        rst_n = 0;
        #1;
        chk("rst_load_drop", ram_load, 0);
        chk("rst_mid_wr_ready", wr_ready, 0);
        chk("rst_mid_cmd_ready", cmd_ready, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_addr", ram_address, 0);
        @(posedge clk); #1 wr_valid = 0;
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        do_read(20, 4, 0);
        chk("rst_w0", got[0], 16'he000);
        chk("rst_w1", got[1], 16'he001);
        chk("rst_w2", got[2], 16'd22);
        chk("rst_w3", got[3], 16'd23);
        chk("rst_w4", got[4], 16'd24);

        // randomized traffic, checked by the model every cycle
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(1) != 0) do_write(6'($urandom), 6'($urandom_range(7)), 16'($urandom), 1);
            else do_read(6'($urandom), 6'($urandom_range(7)), 1);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
